// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative RV-M multiply/divide unit.
package mul_div_unit_pkg;

  // RV-M funct3 encodings
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompute = 2'd1,
    StFinish  = 2'd2
  } state_e;

  // rs1 is treated as two's complement
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV-M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator and one XLEN+1 bit adder/subtractor.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  op_e               op_q;
  logic              neg_q;      // product / quotient needs negation
  logic              rem_neg_q;  // remainder takes dividend sign
  logic              special_q;  // result precomputed at accept (div by zero / overflow)
  logic              dbz_q;
  logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // {high, low}: product, or {remainder, quotient}
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              accept, a_neg, b_neg, dz, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_val, fin_val;
  logic [XLEN:0]     add_a, add_b, add_res;
  logic [2*XLEN-1:0] acc_step, prod;

  // Accept decode, operand magnitudes and the shortcut cases
  always_comb begin
    accept      = (state_q == StIdle) && start;
    a_neg       = a_is_signed(op) && operand_a[XLEN-1];
    b_neg       = b_is_signed(op) && operand_b[XLEN-1];
    a_mag       = a_neg ? -operand_a : operand_a;
    b_mag       = b_neg ? -operand_b : operand_b;
    dz          = op[2] && (operand_b == '0);
    ovf         = op[2] && !op[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                  && (operand_b == '1);
    special_val = '1;
    if (dz) begin
      special_val = op[1] ? operand_a : '1;
    end else begin
      special_val = op[1] ? '0 : operand_a;
    end
  end

  // Shared adder: add for multiply, trial subtract of the shifted remainder for divide
  always_comb begin
    add_b = {1'b0, opnd_q};
    if (op_q[2]) begin
      add_a   = acc_q[2*XLEN-1:XLEN-1];
      add_res = add_a - add_b;
      // Borrow set means the trial subtraction failed: shift in a zero quotient bit
      acc_step = add_res[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {add_res[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      add_a    = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_res  = add_a + add_b;
      acc_step = acc_q[0] ? {add_res, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // Sign correction and result selection while in FINISH
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    fin_val = '0;
    if (special_q) begin
      fin_val = result_q;
    end else begin
      unique case (op_q)
        OpMul:                      fin_val = prod[XLEN-1:0];
        OpMulh, OpMulhsu, OpMulhu:  fin_val = prod[2*XLEN-1:XLEN];
        OpDiv, OpDivu:              fin_val = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        OpRem, OpRemu:              fin_val = rem_neg_q ? -acc_q[2*XLEN-1:XLEN]
                                                        : acc_q[2*XLEN-1:XLEN];
        default:                    fin_val = '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = (dz || ovf) ? StFinish : StCompute;
      StCompute: if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFinish;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath registers: latch on accept, iterate in COMPUTE, hold result on FINISH exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OpMul;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      dbz_q     <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= op_e'(op);
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      special_q <= dz || ovf;
      dbz_q     <= dz;
      cnt_q     <= '0;
      if (dz || ovf) result_q <= special_val;
      if (op[2]) begin
        opnd_q <= b_mag;
        acc_q  <= {{XLEN{1'b0}}, a_mag};
      end else begin
        opnd_q <= a_mag;
        acc_q  <= {{XLEN{1'b0}}, b_mag};
      end
    end else if (state_q == StCompute) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == StFinish) begin
      result_q <= fin_val;
      cnt_q    <= '0;
    end
  end

  // Outputs
  always_comb begin
    ready       = (state_q == StIdle);
    busy        = ~ready;
    done        = (state_q == StFinish);
    result      = (state_q == StFinish) ? fin_val : result_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit at XLEN=32 and XLEN=64.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        s32, s64;
  logic [2:0]  op32, op64;
  logic [31:0] a32, b32, r32;
  logic [63:0] a64, b64, r64;
  logic        rdy32, bsy32, dn32, dz32;
  logic        rdy64, bsy64, dn64, dz64;

  int n_checks = 0;
  int n_errors = 0;

  mul_div_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(s32), .op(op32), .operand_a(a32), .operand_b(b32),
    .ready(rdy32), .busy(bsy32), .done(dn32), .result(r32), .div_by_zero(dz32)
  );

  mul_div_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(s64), .op(op64), .operand_a(a64), .operand_b(b64),
    .ready(rdy64), .busy(bsy64), .done(dn64), .result(r64), .div_by_zero(dz64)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: RV-M semantics evaluated with 128-bit arithmetic
  function automatic logic [63:0] ref_model(input bit wide, input logic [2:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p, x;
    logic [63:0]  ones, am, bm;
    ones = wide ? '1 : 64'h0000_0000_FFFF_FFFF;
    am   = a & ones;
    bm   = b & ones;
    sa   = wide ? {{64{am[63]}}, am} : {{96{am[31]}}, am[31:0]};
    sb   = wide ? {{64{bm[63]}}, bm} : {{96{bm[31]}}, bm[31:0]};
    ua   = {64'b0, am};
    ub   = {64'b0, bm};
    x    = '0;
    case (o)
      3'b000: x = ua * ub;
      3'b001: begin p = sa * sb; x = wide ? (p >> 64) : (p >> 32); end
      3'b010: begin p = sa * ub; x = wide ? (p >> 64) : (p >> 32); end
      3'b011: begin p = ua * ub; x = wide ? (p >> 64) : (p >> 32); end
      3'b100: x = (bm == 0) ? {64'b0, ones} : 128'($signed(sa) / $signed(sb));
      3'b101: x = (bm == 0) ? {64'b0, ones} : ua / ub;
      3'b110: x = (bm == 0) ? ua : 128'($signed(sa) % $signed(sb));
      default: x = (bm == 0) ? ua : ua % ub;
    endcase
    return x[63:0] & ones;
  endfunction

  function automatic int exp_latency(input bit wide, input logic [2:0] o,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ones, minv;
    ones = wide ? '1 : 64'h0000_0000_FFFF_FFFF;
    minv = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (o[2] && ((b & ones) == 0)) return 1;
    if (o[2] && !o[0] && ((a & ones) == minv) && ((b & ones) == ones)) return 1;
    return wide ? 65 : 33;
  endfunction

  function automatic logic [63:0] rand_opnd(input bit wide);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 0;
      1: v = '1;
      2: v = wide ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: v = 64'($urandom_range(1, 20));
      4: v = -64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return wide ? v : {32'b0, v[31:0]};
  endfunction

  // Issue one op, optionally pulse start while busy, and measure latency in cycles
  task automatic run_op(input bit wide, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input bit poke, output logic [63:0] r,
                        output logic z, output int lat);
    @(negedge clk);
    if (wide) begin op64 = o; a64 = a; b64 = b; s64 = 1'b1; end
    else begin op32 = o; a32 = a[31:0]; b32 = b[31:0]; s32 = 1'b1; end
    @(posedge clk); #1;
    s32 = 1'b0; s64 = 1'b0;
    op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
    op64 = 3'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    check_eq("busy_after_accept", wide ? bsy64 : bsy32, 1'b1);
    lat = 1;
    while (!(wide ? dn64 : dn32) && lat < 200) begin
      if (poke && lat == 5) begin
        if (wide) s64 = 1'b1; else s32 = 1'b1;
      end else begin
        s32 = 1'b0; s64 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    s32 = 1'b0; s64 = 1'b0;
    r = wide ? r64 : {32'b0, r32};
    z = wide ? dz64 : dz32;
    @(posedge clk); #1;
    check_eq("done_single_cycle", wide ? dn64 : dn32, 1'b0);
    check_eq("ready_after_done", wide ? rdy64 : rdy32, 1'b1);
    check_eq("result_held", wide ? r64 : {32'b0, r32}, r);
  endtask

  task automatic verify(input bit wide, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input bit poke);
    logic [63:0] r;
    logic        z;
    int          lat;
    logic [63:0] ones;
    ones = wide ? '1 : 64'h0000_0000_FFFF_FFFF;
    run_op(wide, o, a, b, poke, r, z, lat);
    check_eq($sformatf("result w%0d op%0d a=%h b=%h", wide ? 64 : 32, o, a, b), r,
             ref_model(wide, o, a, b));
    check_eq($sformatf("div_by_zero op%0d b=%h", o, b), z, o[2] && ((b & ones) == 0));
    check_eq($sformatf("latency op%0d a=%h b=%h", o, a, b), 64'(lat),
             64'(exp_latency(wide, o, a, b)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    int          lat;
    logic [2:0]  o;
    logic [63:0] a, b;

    reset = 1'b1;
    s32 = 1'b0; s64 = 1'b0; op32 = '0; op64 = '0;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    #12;
    check_eq("reset_ready", rdy32, 1'b1);
    check_eq("reset_busy", bsy32, 1'b0);
    check_eq("reset_done", dn32, 1'b0);
    check_eq("reset_result", r32, 0);
    check_eq("reset_dbz", dz32, 1'b0);
    check_eq("reset_ready64", rdy64, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner vectors at XLEN=32
    verify(1'b0, 3'b000, 64'd7, 64'hFFFF_FFFD, 1'b0);
    verify(1'b0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    verify(1'b0, 3'b001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    verify(1'b0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    verify(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, 1'b0);
    verify(1'b0, 3'b110, 64'hFFFF_FFF9, 64'd2, 1'b0);
    verify(1'b0, 3'b101, 64'd100, 64'd7, 1'b0);
    verify(1'b0, 3'b111, 64'd100, 64'd7, 1'b0);
    verify(1'b0, 3'b100, 64'd5, 64'd0, 1'b0);
    verify(1'b0, 3'b110, 64'd5, 64'd0, 1'b0);
    verify(1'b0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0);
    verify(1'b0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0);
    // Start pulsed mid-compute must be ignored
    verify(1'b0, 3'b000, 64'd1234, 64'd5678, 1'b1);

    // Randomized ops at XLEN=32
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom);
      a = rand_opnd(1'b0);
      b = rand_opnd(1'b0);
      verify(1'b0, o, a, b, ($urandom_range(0, 3) == 0));
    end

    // XLEN=64
    verify(1'b1, 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
    verify(1'b1, 3'b000, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
    verify(1'b1, 3'b100, 64'h8000_0000_0000_0000, '1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      o = 3'($urandom);
      a = rand_opnd(1'b1);
      b = rand_opnd(1'b1);
      verify(1'b1, o, a, b, ($urandom_range(0, 3) == 0));
    end

    // Reset around iteration 10 of a multiply
    @(negedge clk);
    op32 = 3'b000; a32 = 32'd99; b32 = 32'd77; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_ready", rdy32, 1'b1);
    check_eq("abort_busy", bsy32, 1'b0);
    check_eq("abort_done", dn32, 1'b0);
    check_eq("abort_result", r32, 0);
    check_eq("abort_dbz", dz32, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn32) seen++;
    end
    check_eq("no_done_after_abort", 64'(seen), 0);

    // Start presented as reset deasserts is taken on the very next edge
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op32 = 3'b101; a32 = 32'd100; b32 = 32'd7; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    check_eq("accept_after_reset", bsy32, 1'b1);
    lat = 1;
    while (!dn32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("post_reset_latency", 64'(lat), 64'd33);
    check_eq("post_reset_result", r32, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
